// File: rtl/i2c_pkg.sv
// Shared I2C definitions: command encodings, the bit-phase state enum,
// quarter-bit period derivation and the per-phase line table used by the
// bit-level master driver.
package i2c_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_STOP  = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_READ  = 2'd3
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PA,
    ST_PB,
    ST_PC,
    ST_PD
  } state_t;

  // Quarter-bit period in clk cycles: 2.5 us per quarter gives a 10 us bit
  // (100 kHz). Clamped to 1 so very slow clocks still produce a valid timer.
  function automatic int unsigned calc_per_q(input int unsigned us);
    int unsigned q;
    q = (25 * us) / 10;
    return (q < 1) ? 1 : q;
  endfunction

  // Line levels {scl, sda} driven during phase ph of command c.
  // scl_cur is the present SCL output, held through START's first phase so a
  // repeated START does not glitch SCL high before SDA is released.
  function automatic logic [1:0] phase_lines(input cmd_t c, input logic d,
                                             input state_t ph, input logic scl_cur);
    logic [1:0] l;
    l = 2'b11;
    case (c)
      CMD_START: begin
        case (ph)
          ST_PB:   l = 2'b11;
          ST_PC:   l = 2'b10;
          ST_PD:   l = 2'b00;
          default: l = {scl_cur, 1'b1};
        endcase
      end
      CMD_STOP: begin
        case (ph)
          ST_PA:   l = 2'b00;
          ST_PB:   l = 2'b10;
          default: l = 2'b11;
        endcase
      end
      default: begin
        // WRITE and READ: SCL high only in the middle two phases; READ
        // releases SDA so the slave can drive it.
        l = {(ph == ST_PB) || (ph == ST_PC), (c == CMD_READ) ? 1'b1 : d};
      end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/i2c_phase_timer.sv
// Quarter-bit phase timer: loadable down-counter with a hold input.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - load PER_Q-1 (asserted on phase entry)
//   hold      - freeze the count (SCL stretched by a slave)
//   zero      - counter is at 0 (last cycle of the phase unless held)
module i2c_phase_timer #(
  parameter int unsigned PER_Q = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic hold,
  output logic zero
);

  localparam int CW = $clog2(PER_Q + 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(PER_Q - 1);
    end else if (!hold && (cnt != '0)) begin
      // Decrement only when nonzero so the counter can never wrap.
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/i2c_bit_ctl.sv
// Bit-level I2C master line driver. Executes one START/STOP/WRITE/READ
// command as four timed quarter-bit phases on open-drain SCL/SDA, with
// slave clock stretching and arbitration-loss detection.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   cmd, cmd_vld     - command (0 START, 1 STOP, 2 WRITE, 3 READ) and valid
//   cmd_rdy          - idle, able to accept a command
//   din              - bit to write, captured on acceptance
//   dout             - bit sampled on the last cycle of PC (READ/WRITE)
//   done             - one-cycle completion/abort pulse
//   arb_lost         - one-cycle pulse with done when arbitration is lost
//   scl_i, sda_i     - synchronized bus levels
//   scl_o, sda_o     - registered line outputs (0 drive low, 1 release)
module i2c_bit_ctl
  import i2c_pkg::*;
#(
  parameter int unsigned US = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] cmd,
  input  logic       cmd_vld,
  output logic       cmd_rdy,
  input  logic       din,
  output logic       dout,
  output logic       done,
  output logic       arb_lost,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o
);

  localparam int unsigned PER_Q = calc_per_q(US);

  state_t     state, state_nxt;
  cmd_t       cmd_q, cmd_nxt;
  logic       din_q, din_nxt;
  logic       scl_nxt, sda_nxt, done_nxt, arb_nxt, dout_nxt;
  logic       load, hold, zero, phase_end, abort;
  logic [1:0] lines;

  // A slave holding SCL low during PB freezes the phase timer.
  assign hold      = (state == ST_PB) && !scl_i;
  assign phase_end = zero && !hold;
  assign cmd_rdy   = (state == ST_IDLE);

  i2c_phase_timer #(.PER_Q(PER_Q)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .hold (hold),
    .zero (zero)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    cmd_nxt   = cmd_q;
    din_nxt   = din_q;
    scl_nxt   = scl_o;
    sda_nxt   = sda_o;
    done_nxt  = 1'b0;
    arb_nxt   = 1'b0;
    dout_nxt  = dout;
    load      = 1'b0;
    abort     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cmd_vld) begin
          state_nxt = ST_PA;
          cmd_nxt   = cmd_t'(cmd);
          din_nxt   = din;
          load      = 1'b1;
        end
      end
      ST_PA: begin
        if (phase_end) begin
          state_nxt = ST_PB;
          load      = 1'b1;
        end
      end
      ST_PB: begin
        if (phase_end) begin
          // START lost if another master holds SDA low while we release it.
          if ((cmd_q == CMD_START) && !sda_i) begin
            abort = 1'b1;
          end else begin
            state_nxt = ST_PC;
            load      = 1'b1;
          end
        end
      end
      ST_PC: begin
        if (phase_end) begin
          if ((cmd_q == CMD_WRITE) || (cmd_q == CMD_READ)) begin
            dout_nxt = sda_i;
          end
          if (((cmd_q == CMD_STOP) || ((cmd_q == CMD_WRITE) && din_q)) && !sda_i) begin
            abort = 1'b1;
          end else begin
            state_nxt = ST_PD;
            load      = 1'b1;
          end
        end
      end
      ST_PD: begin
        if (phase_end) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Lines are registered, so they are computed from the next state: the
    // new phase's levels appear on the same cycle the phase begins.
    lines = phase_lines(cmd_nxt, din_nxt, state_nxt, scl_o);

    if (abort) begin
      state_nxt = ST_IDLE;
      done_nxt  = 1'b1;
      arb_nxt   = 1'b1;
      scl_nxt   = 1'b1;
      sda_nxt   = 1'b1;
    end else if (state_nxt != ST_IDLE) begin
      {scl_nxt, sda_nxt} = lines;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cmd_q    <= CMD_START;
      din_q    <= 1'b0;
      scl_o    <= 1'b1;
      sda_o    <= 1'b1;
      done     <= 1'b0;
      arb_lost <= 1'b0;
      dout     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cmd_q    <= cmd_nxt;
      din_q    <= din_nxt;
      scl_o    <= scl_nxt;
      sda_o    <= sda_nxt;
      done     <= done_nxt;
      arb_lost <= arb_nxt;
      dout     <= dout_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_bit_ctl.sv
// Scoreboard bench for i2c_bit_ctl at US = 4 (quarter-bit = 10 cycles).
// Stimulus pushes expected line levels (per absolute cycle) and expected
// done events; a negedge monitor pops and compares as the DUT presents them.
module tb_i2c_bit_ctl;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cmd;
  logic       cmd_vld;
  logic       cmd_rdy;
  logic       din;
  logic       dout;
  logic       done;
  logic       arb_lost;
  logic       scl_i, sda_i;
  logic       scl_o, sda_o;
  logic       scl_drv, sda_drv;

  // Wired-AND bus: the bench plays slave/other master through *_drv.
  assign scl_i = scl_o & scl_drv;
  assign sda_i = sda_o & sda_drv;

  i2c_bit_ctl #(.US(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd),
    .cmd_vld  (cmd_vld),
    .cmd_rdy  (cmd_rdy),
    .din      (din),
    .dout     (dout),
    .done     (done),
    .arb_lost (arb_lost),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_o    (scl_o),
    .sda_o    (sda_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic scl; logic sda; } line_exp_t;
  typedef struct { int cyc; logic arb; logic chk_dout; logic dout; } done_exp_t;

  line_exp_t lq[$];
  done_exp_t dq[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_line(input int c, input logic s_scl, input logic s_sda);
    lq.push_back('{cyc: c, scl: s_scl, sda: s_sda});
  endtask

  task automatic push_done(input int c, input logic arb, input logic chk, input logic d);
    dq.push_back('{cyc: c, arb: arb, chk_dout: chk, dout: d});
  endtask

  // Expected lines at first and last cycle of each phase of a command
  // accepted at cycle a; st = stretch cycles added to PB. Bit p = phase p.
  task automatic push_cmd(input int a, input int st, input logic [3:0] scl_v, input logic [3:0] sda_v);
    int s, e;
    for (int p = 0; p < 4; p++) begin
      s = a + 1 + p * Q + ((p >= 2) ? st : 0);
      e = s + Q - 1 + ((p == 1) ? st : 0);
      push_line(s, scl_v[p], sda_v[p]);
      push_line(e, scl_v[p], sda_v[p]);
    end
  endtask

  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Present a command at the negedge of cycle a; accepted by the next edge.
  task automatic issue(input int a, input logic [1:0] c, input logic d);
    at_cyc(a);
    cmd_vld = 1'b1;
    cmd     = c;
    din     = d;
    at_cyc(a + 1);
    cmd_vld = 1'b0;
  endtask

  // Monitor: compares lines on their scheduled cycles and done events.
  line_exp_t le;
  done_exp_t de;
  always @(negedge clk) begin
    while (lq.size() > 0 && lq[0].cyc <= cyc) begin
      le = lq.pop_front();
      if (le.cyc < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL stale_line: expectation for cycle %0d seen at %0d", le.cyc, cyc);
      end else begin
        check($sformatf("lines@%0d {scl,sda}", le.cyc), {30'd0, scl_o, sda_o}, {30'd0, le.scl, le.sda});
      end
    end
    if (arb_lost && !done) check("arb_without_done", {31'd0, done}, 32'd1);
    if (done) begin
      if (dq.size() == 0) begin
        check("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        de = dq.pop_front();
        check("done_cycle", cyc, de.cyc);
        check($sformatf("arb_lost@%0d", de.cyc), {31'd0, arb_lost}, {31'd0, de.arb});
        check($sformatf("cmd_rdy_at_done@%0d", de.cyc), {31'd0, cmd_rdy}, 32'd1);
        if (de.chk_dout) check($sformatf("dout@%0d", de.cyc), {31'd0, dout}, {31'd0, de.dout});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  int a;

  initial begin
    rst = 1'b1; cmd = 2'd0; cmd_vld = 1'b0; din = 1'b0;
    scl_drv = 1'b1; sda_drv = 1'b1;
    @(negedge clk);
    at_cyc(2);
    check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_arb_lost", {31'd0, arb_lost}, 32'd0);
    check("rst_dout", {31'd0, dout}, 32'd0);
    check("rst_scl_o", {31'd0, scl_o}, 32'd1);
    check("rst_sda_o", {31'd0, sda_o}, 32'd1);
    at_cyc(3);
    rst = 1'b0;

    // START from idle: sda falls at a+21 with scl high, scl falls at a+31.
    a = 5;
    push_cmd(a, 0, 4'b0111, 4'b0011);
    push_done(a + 41, 1'b0, 1'b0, 1'b0);
    issue(a, 2'd0, 1'b0);
    // STOP accepted on the START done cycle.
    a = 46;
    push_cmd(a, 0, 4'b1110, 4'b1100);
    push_done(a + 41, 1'b0, 1'b0, 1'b0);
    issue(a, 2'd1, 1'b0);

    // WRITE 0, no stretch; readback 0.
    a = 95;
    push_cmd(a, 0, 4'b0110, 4'b0000);
    push_done(a + 41, 1'b0, 1'b1, 1'b0);
    issue(a, 2'd2, 1'b0);

    // WRITE 1 with SDA pulled low during PC: arbitration lost, PD skipped.
    a = 145;
    push_line(a + 1, 1'b0, 1'b1);  push_line(a + 10, 1'b0, 1'b1);
    push_line(a + 11, 1'b1, 1'b1); push_line(a + 20, 1'b1, 1'b1);
    push_line(a + 21, 1'b1, 1'b1); push_line(a + 30, 1'b1, 1'b1);
    push_line(a + 31, 1'b1, 1'b1); push_line(a + 35, 1'b1, 1'b1);
    push_done(a + 31, 1'b1, 1'b1, 1'b0);
    issue(a, 2'd2, 1'b1);
    at_cyc(a + 21); sda_drv = 1'b0;
    at_cyc(a + 31); sda_drv = 1'b1;

    // READ with 15 cycles of SCL stretch at PB entry; sda released -> dout 1.
    a = 185;
    push_cmd(a, 15, 4'b0110, 4'b1111);
    push_done(a + 56, 1'b0, 1'b1, 1'b1);
    issue(a, 2'd3, 1'b0);
    at_cyc(a + 11); scl_drv = 1'b0;
    at_cyc(a + 26); scl_drv = 1'b1;

    // Reset in cycle a+15 (mid-PB): released lines, idle, dout cleared, no done.
    a = 250;
    push_line(a + 1, 1'b0, 1'b0);  push_line(a + 10, 1'b0, 1'b0);
    push_line(a + 11, 1'b1, 1'b0); push_line(a + 15, 1'b1, 1'b0);
    push_line(a + 16, 1'b1, 1'b1); push_line(a + 20, 1'b1, 1'b1);
    issue(a, 2'd2, 1'b0);
    at_cyc(a + 15); rst = 1'b1;
    at_cyc(a + 16); rst = 1'b0;
    check("post_rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    check("post_rst_dout", {31'd0, dout}, 32'd0);

    // New command after reset: WRITE 1, readback 1.
    a = 275;
    push_cmd(a, 0, 4'b0110, 4'b1111);
    push_done(a + 41, 1'b0, 1'b1, 1'b1);
    issue(a, 2'd2, 1'b1);

    // READ with SDA low only on the last PC cycle -> dout 0.
    a = 325;
    push_cmd(a, 0, 4'b0110, 4'b1111);
    push_done(a + 41, 1'b0, 1'b1, 1'b0);
    issue(a, 2'd3, 1'b0);
    at_cyc(a + 30); sda_drv = 1'b0;
    at_cyc(a + 31); sda_drv = 1'b1;

    // Back-pressure: cmd_vld held; din toggles while busy. One acceptance
    // per done: WRITE 0 at a, WRITE 1 at a+41.
    a = 375;
    push_cmd(a, 0, 4'b0110, 4'b0000);
    push_done(a + 41, 1'b0, 1'b1, 1'b0);
    push_cmd(a + 41, 0, 4'b0110, 4'b1111);
    push_done(a + 82, 1'b0, 1'b1, 1'b1);
    at_cyc(a);
    cmd_vld = 1'b1; cmd = 2'd2; din = 1'b0;
    for (int c = a + 1; c <= a + 40; c++) begin
      at_cyc(c);
      din = ~din;
      if (c == a + 20) check("busy_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    end
    at_cyc(a + 41); din = 1'b1;
    at_cyc(a + 42); cmd_vld = 1'b0;

    at_cyc(a + 90);
    for (int i = 0; i < 60 && (lq.size() > 0 || dq.size() > 0); i++) @(negedge clk);
    while (lq.size() > 0) begin
      le = lq.pop_front();
      n_vec++; n_err++;
      $display("FAIL missing_line: cycle %0d never checked", le.cyc);
    end
    while (dq.size() > 0) begin
      de = dq.pop_front();
      n_vec++; n_err++;
      $display("FAIL missing_done: expected at cycle %0d, not seen", de.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_bit_ctl.md
# i2c_bit_ctl

Bit-level I2C master line driver, the transmit counterpart of the SDA/SCL edge and bus-busy detector. Accepts one command at a time (START, STOP, WRITE bit, READ bit) and sequences the open-drain SCL/SDA outputs through four timed quarter-bit phases. Supports slave clock stretching and detects arbitration loss. Sits between the byte-level master FSM and the pad open-drain drivers.

## Interface
- `US`, default 1: clock cycles per microsecond.
- `PER_Q`, localparam: quarter-bit period in cycles, max(25*US/10, 1). Gives a 10 us bit (100 kHz) at nominal US.
- `clk` in 1: sole clock.
- `rst` in 1: reset, synchronous, active-high.
- `cmd` in 2: command; 0 = START, 1 = STOP, 2 = WRITE, 3 = READ.
- `cmd_vld` in 1: command valid.
- `cmd_rdy` out 1: block idle and able to accept a command.
- `din` in 1: bit to write; captured when the command is accepted.
- `dout` out 1: bit sampled by READ; also updated by WRITE with the readback.
- `done` out 1: one-cycle pulse when a command completes or aborts.
- `arb_lost` out 1: one-cycle pulse coincident with `done` when arbitration is lost.
- `scl_i`, `sda_i` in 1 each: bus levels, already synchronized upstream.
- `scl_o`, `sda_o` out 1 each: 0 = drive low, 1 = release. Both are registered.

## Operation
- **States:** IDLE, PA, PB, PC, PD. `cmd_rdy` = (state == IDLE).
- **Acceptance:** a command is accepted on `cmd_vld && cmd_rdy`. `cmd` and `din` are latched. The next state is PA and the phase counter loads PER_Q-1.
- **Phase advance:** each phase ends when the counter reaches 0, then the next phase loads PER_Q-1. After PD the block returns to IDLE with `done` = 1.
- **Line values per phase (sda/scl):**
  - START: PA 1/hold current scl_o; PB 1/1; PC 0/1; PD 0/0.
  - STOP: PA 0/0; PB 0/1; PC 1/1; PD 1/1 (bus free time).
  - WRITE: PA din/0; PB din/1; PC din/1; PD din/0.
  - READ: same as WRITE with sda = 1.
- **Clock stretch:** in PB, the counter holds and does not decrement while `scl_i` == 0. Counting begins on the first cycle `scl_i` == 1. There is no timeout.
- **Sampling:** on the last cycle of PC, `dout` <= `sda_i` (READ and WRITE).
- **Arbitration loss.** The checks are:
  - START: `sda_i` == 0 on the last cycle of PB.
  - WRITE with din = 1: `sda_i` == 0 on the last cycle of PC.
  - STOP: `sda_i` == 0 on the last cycle of PC.
  
  On loss, the next state is IDLE, `scl_o` = `sda_o` = 1, and `done` = `arb_lost` = 1 for one cycle. The remaining phases are skipped.
- **Back-to-back commands:** a command may be accepted in the same cycle `done` is high. PA begins the following cycle.
- **Idle lines:** in IDLE, lines hold their last values; SCL stays low after START/WRITE/READ. After an abort, both lines are released.
- **Command sequencing:** the block performs no START/STOP sequencing checks; command order is the caller's responsibility.

## Timing
- **Reset values:** state IDLE, `scl_o` = 1, `sda_o` = 1, `cmd_rdy` = 1, `done` = 0, `arb_lost` = 0, `dout` = 0, counter 0.
- **Reset mid-command:** the block returns to reset values on the next edge. No `done` is produced.
- **Line latency:** with acceptance in cycle 0, lines show PA values from cycle 1. Each phase lasts PER_Q cycles, plus stretch cycles in PB.
- **Completion:** with no stretch, `done` = 1 and `cmd_rdy` = 1 in cycle 4*PER_Q+1.
- **Counter width:** clog2(PER_Q+1) bits. It never wraps: it loads only at phase entry and decrements only when nonzero.
- **Inputs ignored while busy:** `cmd_vld` is ignored outside IDLE, and `din` changes after acceptance have no effect.

## Structure
- **Shared package `i2c_pkg`:**
  - command encodings (CMD_START, CMD_STOP, CMD_WRITE, CMD_READ);
  - phase state enum;
  - PER_Q derivation from US, shared with the detector's timing constants.
- **Sub-module `i2c_phase_timer`:** loadable down-counter with hold input (used for stretching) and a zero flag; parameter PER_Q.

## Test plan
All scenarios use US = 4, so PER_Q = 10.
- **WRITE, no stretch:** accept WRITE din = 0 at cycle 0 -> scl 0/1/1/0 over cycles 1-10/11-20/21-30/31-40, sda = 0 throughout; `done` at cycle 41.
- **START then STOP:** START from idle -> sda falls at cycle 21 while scl = 1, scl falls at cycle 31. STOP accepted on the `done` cycle -> sda rises at the start of its PC with scl = 1; final lines 1/1.
- **Clock stretch:** READ with `scl_i` forced 0 for 15 cycles after PB entry -> PB lasts 25 cycles; `done` at 56; `dout` equals `sda_i` on the last PC cycle (drive 1, then 0 in a second read).
- **Arbitration:** WRITE din = 1 with `sda_i` = 0 during PC -> `done` = `arb_lost` = 1 at cycle 31; `scl_o` = `sda_o` = 1 from 31; PD skipped.
- **Reset mid-PB:** assert `rst` in cycle 15 -> cycle 16 lines 1/1, `cmd_rdy` = 1, no `done`; a new command is accepted normally afterwards.
- **Back-pressure:** `cmd_vld` held during a busy command -> a single acceptance per `done`; `din` toggling after acceptance does not change `sda_o`.
